// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and forwarding controller for an in-order MIPS
// pipeline. Keeps a scoreboard of the NSTAGE writer stages behind ID. From it
// the block derives load-use and branch stalls, multi-cycle EX holds, the IF
// flush, and the operand-forwarding selects for the ID branch comparator and
// the EX ALU.
module pipe_hazard_ctrl #(
    parameter int NSTAGE = 3,
    parameter int REGW   = 5,
    parameter int MULCYC = 4,
    parameter int FW     = $clog2(NSTAGE + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_ra,
    input  logic [REGW-1:0] id_rb,
    input  logic            id_use_a,
    input  logic            id_use_b,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_regwr,
    input  logic            id_load,
    input  logic            id_mcyc,
    input  logic            id_branch,
    input  logic            br_taken,
    output logic            stall_if,
    output logic            stall_id,
    output logic            bubble_ex,
    output logic            ex_hold,
    output logic            if_flush,
    output logic [FW-1:0]   br_fwd_a,
    output logic [FW-1:0]   br_fwd_b,
    output logic [FW-1:0]   ex_fwd_a,
    output logic [FW-1:0]   ex_fwd_b,
    output logic            busy
);

    localparam int SW = $clog2(NSTAGE);
    localparam int CW = $clog2(MULCYC);

    // Scoreboard, index 0 = EX, NSTAGE-1 = WB
    logic [NSTAGE-1:0] v_q;
    logic [NSTAGE-1:0] wr_q;
    logic [NSTAGE-1:0] ld_q;
    logic [NSTAGE-1:0] mc_q;
    logic [REGW-1:0]   rd_q [NSTAGE];

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FW-1:0]     ex_fwd_a_q, ex_fwd_a_d;
    logic [FW-1:0]     ex_fwd_b_q, ex_fwd_b_d;

    logic [NSTAGE-1:0] match_a_s, match_b_s;
    logic [SW-1:0]     stg_a_s, stg_b_s;
    logic              src_a_s, src_b_s;
    logic              at0_a_s, at0_b_s;
    logic [FW-1:0]     fwd_a_s, fwd_b_s;
    logic              lu_s, brs_s, norm_stall_s, hold_s;

    // Youngest-producer lookup for both ID sources (lowest stage index wins)
    always_comb begin
        stg_a_s = '0;
        stg_b_s = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            match_a_s[k] = v_q[k] & wr_q[k] & (rd_q[k] == id_ra) & (id_ra != '0);
            match_b_s[k] = v_q[k] & wr_q[k] & (rd_q[k] == id_rb) & (id_rb != '0);
        end
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            stg_a_s = match_a_s[k] ? SW'(k) : stg_a_s;
            stg_b_s = match_b_s[k] ? SW'(k) : stg_b_s;
        end
        src_a_s = id_valid & id_use_a & (|match_a_s);
        src_b_s = id_valid & id_use_b & (|match_b_s);
        // WB writes the regfile in the first half-cycle, so it needs no bypass
        fwd_a_s = (src_a_s && (stg_a_s < SW'(NSTAGE - 1))) ? (FW'(stg_a_s) + FW'(1)) : '0;
        fwd_b_s = (src_b_s && (stg_b_s < SW'(NSTAGE - 1))) ? (FW'(stg_b_s) + FW'(1)) : '0;
    end

    // Stall classification from the stage-0 producer flags
    always_comb begin
        at0_a_s      = src_a_s & (stg_a_s == '0);
        at0_b_s      = src_b_s & (stg_b_s == '0);
        lu_s         = id_valid & ~id_branch &
                       ((at0_a_s & ld_q[stg_a_s]) | (at0_b_s & ld_q[stg_b_s]));
        brs_s        = id_valid & id_branch &
                       ((at0_a_s & (ld_q[stg_a_s] | mc_q[stg_a_s])) |
                        (at0_b_s & (ld_q[stg_b_s] | mc_q[stg_b_s])));
        norm_stall_s = lu_s | brs_s;
        hold_s       = (cnt_q != '0);
    end

    // Next state of the multi-cycle counter and EX forward selects
    always_comb begin
        if (hold_s) begin
            cnt_d      = cnt_q - CW'(1);
            ex_fwd_a_d = ex_fwd_a_q;
            ex_fwd_b_d = ex_fwd_b_q;
        end else if (norm_stall_s) begin
            cnt_d      = '0;
            ex_fwd_a_d = '0;
            ex_fwd_b_d = '0;
        end else begin
            cnt_d      = (id_valid & id_mcyc) ? CW'(MULCYC - 1) : '0;
            ex_fwd_a_d = fwd_a_s;
            ex_fwd_b_d = fwd_b_s;
        end
    end

    // Scoreboard shift, counter and EX forward-select registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q        <= '0;
            wr_q       <= '0;
            ld_q       <= '0;
            mc_q       <= '0;
            cnt_q      <= '0;
            ex_fwd_a_q <= '0;
            ex_fwd_b_q <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                rd_q[k] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            ex_fwd_a_q <= ex_fwd_a_d;
            ex_fwd_b_q <= ex_fwd_b_d;
            for (int k = 1; k < NSTAGE; k++) begin
                v_q[k]  <= v_q[k-1];
                wr_q[k] <= wr_q[k-1];
                ld_q[k] <= ld_q[k-1];
                mc_q[k] <= mc_q[k-1];
                rd_q[k] <= rd_q[k-1];
            end
            if (hold_s) begin
                // EX frozen: MEM sees a bubble, older stages keep draining
                v_q[1] <= 1'b0;
            end else begin
                v_q[0]  <= id_valid & ~norm_stall_s;
                wr_q[0] <= id_regwr;
                ld_q[0] <= id_load;
                mc_q[0] <= id_mcyc;
                rd_q[0] <= id_rd;
            end
        end
    end

    assign stall_if  = hold_s | norm_stall_s;
    assign stall_id  = hold_s | norm_stall_s;
    assign bubble_ex = ~hold_s & norm_stall_s;
    assign ex_hold   = hold_s;
    assign busy      = hold_s;
    assign if_flush  = br_taken & id_valid & ~(hold_s | norm_stall_s);
    assign br_fwd_a  = fwd_a_s;
    assign br_fwd_b  = fwd_b_s;
    assign ex_fwd_a  = ex_fwd_a_q;
    assign ex_fwd_b  = ex_fwd_b_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for an in-order MIPS pipeline with NSTAGE writer stages after ID (default EX, MEM, WB).
- Replaces fixed 3-stage forwarding, load-use and branch-bubble logic with one block that owns a per-stage scoreboard.
- Adds multi-cycle EX ops (mul/div) that hold EX for MULCYC cycles while later stages drain.
- Sits beside the ID stage. Drives stall, flush and bubble controls plus the operand-mux selects for the ID branch comparator and the EX ALU.

Parameters:
- NSTAGE, 3, number of tracked stages after ID (index 0=EX, NSTAGE-1=WB); legal range is NSTAGE >= 3.
- REGW, 5, register-index width.
- MULCYC, 4, EX occupancy in cycles of a multi-cycle op; legal range is MULCYC >= 2.
- FW, $clog2(NSTAGE+1), width of the forward-select codes.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- id_valid  input  1  ID holds a real instruction.
- id_ra, id_rb  input  REGW  ID source registers.
- id_use_a, id_use_b  input  1  the source is actually read.
- id_rd  input  REGW  ID destination (after regDst/jal select).
- id_regwr  input  1  ID instruction writes the register file.
- id_load  input  1  ID instruction is a load.
- id_mcyc  input  1  ID instruction is a multi-cycle EX op.
- id_branch  input  1  ID instruction compares operands in ID (beq/bne/bgez/…/jalr).
- br_taken  input  1  ID redirect resolved taken.
- stall_if  output  1  hold PC.
- stall_id  output  1  hold IF/ID register.
- bubble_ex  output  1  load a bubble into ID/EX.
- ex_hold  output  1  hold ID/EX register and ALU inputs.
- if_flush  output  1  squash IF/ID.
- br_fwd_a, br_fwd_b  output  FW  combinational branch-operand select: 0=regfile, k+1=result of stage k.
- ex_fwd_a, ex_fwd_b  output  FW  registered ALU-operand select for the instruction now in EX: 0=ID/EX latched value, k=stage k result (k=1..NSTAGE-1).
- busy  output  1  multi-cycle op in progress.

Behaviour:
- Scoreboard: per stage k, holds v[k], rd[k], wr[k], ld[k] and mc[k].
- A stage entry is a producer for source s when v & wr & rd==s & s!=0. The youngest producer (lowest k) wins.
- The register file writes in the first half-cycle, so a producer at stage NSTAGE-1 counts as no hazard.
- Load-use: stall when id_valid & ~id_branch, a source is used, and its producer is at stage 0 with ld[0].
- Branch stall: stall when id_branch, and a used source's producer is at stage 0 with (ld[0] | mc[0]).
- Branch forwarding: br_fwd = k+1 for a producer at stage k < NSTAGE-1, else 0.
- EX forwarding: ex_fwd is computed in ID as (producer stage)+1 when that stage is < NSTAGE-1, else 0. It is registered into ex_fwd when ID advances.
- Multi-cycle op: when an entry with mc enters stage 0, a counter loads MULCYC-1 and busy=1. While the counter != 0:
  - ex_hold=1, stall_if=1, stall_id=1.
  - The counter decrements each cycle.
  - Stage 0 is frozen; stage 1 receives a bubble (v=0); stages >=2 shift normally.
  - On the cycle the counter reads 1, the hold releases after that edge. Total EX occupancy is exactly MULCYC cycles.
- Normal stall (load-use or branch): stall_if=stall_id=1 and bubble_ex=1. Stage 0 gets v=0, all later stages shift, and ex_fwd is cleared to 0.
- Flush: if_flush = br_taken & id_valid & ~stall_id. br_taken is ignored while stall_id=1.
- Priority: ex_hold > load-use/branch stall > flush. During ex_hold, bubble_ex=0.
- Shift: on an unstalled cycle, stage 0 <- ID fields (v=id_valid) and stage k <- stage k-1.
- Reset (rst=0, asynchronous): every v=0, counter=0, ex_fwd_*=0. All outputs are 0 and stay 0 until the first instruction.
- Reset mid multi-cycle op aborts it and busy clears immediately.
- All stall outputs are combinational from scoreboard state plus ID inputs. No extra latency.

Test Plan:
- Forwarding chains: add r3 ← r1+r2 then sub r4 ← r3-r5 back-to-back → no stall, ex_fwd_a=1 in the sub's EX cycle. With one independent op between them → ex_fwd_a=2. With two between → ex_fwd_a=0.
- Load-use: lw r8 then add r9 ← r8+r0 → one cycle of stall_if=stall_id=bubble_ex=1, then ex_fwd_a=2. Reading r0 as a source after "lw r0" → no stall.
- Branch after ALU and after load:
  - add r3 then beq r3,r4 → br_fwd_a=1 and no stall.
  - lw r3 then beq r3 → one stall, then br_fwd_a=2.
  - A taken beq → if_flush=1 for exactly one cycle.
- Multi-cycle op (MULCYC=4): mult then add → busy=ex_hold=1 for 3 cycles, EX occupancy 4 cycles. The MEM stage shows bubbles during the hold and the older WB entry retires normally.
- Simultaneous events: br_taken together with load-use stall → if_flush=0 that cycle, and if_flush=1 on the cycle after the stall clears. Assert rst mid-hold → busy=0 and all outputs 0 asynchronously.
- Parameter sweep: NSTAGE=5 with a producer at stage 3 → br_fwd=4. ex_fwd never exceeds 4; stage 4 is treated as the regfile.
